data_mem_controller: RTL and testbench

Data-memory responder on the far side of the EX/MEM pipeline register. It accepts the MEM-stage request: read control, write control, byte address (ALU result) and store data (rs2). It stalls the pipeline through `busywait` for a programmable number of wait states, then performs the RV32IM load or store with byte/halfword lane steering and sign/zero extension. It contains its own word-organised storage array, so the pipeline has a self-contained, multi-cycle data memory.

---
 rtl/data_mem_controller.sv | 149 ++++++++++++++
 tb/tb_data_mem_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_controller.sv
// rtl/data_mem_controller.sv - multi-cycle RV32 data memory with wait states and lane steering
module data_mem_controller #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_read,
    input  logic [2:0]  mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        busywait,
    output logic [31:0] read_data,
    output logic        misaligned
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              req, req_legal;
    logic [1:0]        size_code;
    size_t             req_size;

    logic              wr_r, both_r, uns_r, mis_r;
    size_t             size_r;
    logic [1:0]        lane_r;
    logic [IDX_W-1:0]  idx_r;
    logic [31:0]       wdata_r;

    logic [31:0]       word_q, byte_sh, load_val, wmask, wdata_rep;
    logic              commit;
    logic              unused_addr;

    assign unused_addr = ^address[31:IDX_W+2];

    // Load funct3[1:0] and store size share one encoding: 00 byte, 01 half, else word.
    always_comb begin
        req       = mem_read[3] | mem_write[2];
        size_code = mem_write[2] ? mem_write[1:0] : mem_read[1:0];
        case (size_code)
            2'b00:   req_size = SZ_BYTE;
            2'b01:   req_size = SZ_HALF;
            default: req_size = SZ_WORD;
        endcase
        req_legal = !((req_size == SZ_HALF && address[0]) ||
                      (req_size == SZ_WORD && address[1:0] != 2'b00));
    end

    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            wr_r    <= mem_write[2];
            both_r  <= mem_write[2] & mem_read[3];
            uns_r   <= mem_read[2];
            mis_r   <= !req_legal;
            size_r  <= req_size;
            lane_r  <= address[1:0];
            idx_r   <= address[IDX_W+1:2];
            wdata_r <= write_data;
        end
    end

    assign word_q  = mem[idx_r];
    assign byte_sh = word_q >> {lane_r, 3'b000};
    assign commit  = (state == ACCESS) && (cnt == '0);

    always_comb begin
        load_val  = word_q;
        wmask     = 32'hFFFF_FFFF;
        wdata_rep = wdata_r;
        case (size_r)
            SZ_BYTE: begin
                load_val  = {{24{byte_sh[7] & !uns_r}}, byte_sh[7:0]};
                wmask     = 32'h0000_00FF << {lane_r, 3'b000};
                wdata_rep = {4{wdata_r[7:0]}};
            end
            SZ_HALF: begin
                load_val  = lane_r[1] ? {{16{word_q[31] & !uns_r}}, word_q[31:16]}
                                      : {{16{word_q[15] & !uns_r}}, word_q[15:0]};
                wmask     = lane_r[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wdata_rep = {2{wdata_r[15:0]}};
            end
            default: ;
        endcase
    end

    // Read-modify-write keeps unselected bytes; a reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_r)
            mem[idx_r] <= (word_q & ~wmask) | (wdata_rep & wmask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            read_data <= 32'h0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req && req_legal)
                        cnt <= CNT_W'(LATENCY - 1);
                    if (req && !req_legal)
                        read_data <= 32'h0;
                end
                ACCESS: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else if (both_r)
                        read_data <= 32'h0;
                    else if (!wr_r)
                        read_data <= load_val;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        busywait   = 1'b0;
        misaligned = 1'b0;
        case (state)
            IDLE: begin
                busywait = req;
                if (req)
                    state_nxt = req_legal ? ACCESS : DONE;
            end
            ACCESS: begin
                busywait = 1'b1;
                if (cnt == '0)
                    state_nxt = DONE;
            end
            DONE: begin
                misaligned = mis_r;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// tb/tb_data_mem_controller.sv - randomized self-checking bench against a byte-array memory model
module tb_data_mem_controller;

    localparam int DEPTH = 256;
    localparam int LAT   = 4;
    localparam int NBYTE = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        busywait;
    logic [31:0] read_data;
    logic        misaligned;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  ref_mem [NBYTE];
    logic [31:0] exp_rd;

    data_mem_controller #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .busywait   (busywait),
        .read_data  (read_data),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        mem_read   = 4'b0;
        mem_write  = 3'b0;
        address    = 32'h0;
        write_data = 32'h0;
    endtask

    // Applies the rules of RV32 loads/stores to a flat byte array.
    task automatic model(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                         input logic [31:0] wd, output logic legal);
        logic [1:0]  code;
        int          nb, a;
        logic [31:0] v;
        code  = wr[2] ? wr[1:0] : rd[1:0];
        nb    = (code == 2'd0) ? 1 : (code == 2'd1) ? 2 : 4;
        a     = int'(addr % NBYTE);
        legal = (a % nb) == 0;
        if (!legal) begin
            exp_rd = 32'h0;
        end else if (wr[2]) begin
            for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
            if (rd[3]) exp_rd = 32'h0;
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
            if (!rd[2] && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!rd[2] && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
            exp_rd = v;
        end
    endtask

    task automatic access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                          input logic [31:0] wd);
        logic rq, legal;
        int   busy, cycles;
        @(negedge clk);
        check("mis_idle", 32'(misaligned), 32'h0);
        mem_read = rd; mem_write = wr; address = addr; write_data = wd;
        #1;
        rq = rd[3] | wr[2];
        check("busy_req", 32'(busywait), 32'(rq));
        if (!rq) begin
            clear_inputs();
            return;
        end
        model(rd, wr, addr, wd, legal);
        busy = 0; cycles = 0;
        while (busywait && cycles < 50) begin
            busy++;
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 50) check("busy_timeout", 32'h1, 32'h0);
        check("busy_cycles", 32'(busy), legal ? 32'(LAT + 1) : 32'h1);
        check("misaligned", 32'(misaligned), 32'(!legal));
        check("read_data", read_data, exp_rd);
        clear_inputs();
    endtask

    task automatic reset_mid_store(input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        mem_read = 4'b0; mem_write = 3'b110; address = addr; write_data = wd;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        #1;
        exp_rd = 32'h0;
        check("rst_busy", 32'(busywait), 32'h0);
        check("rst_rdata", read_data, 32'h0);
        check("rst_mis", 32'(misaligned), 32'h0);
    endtask

    initial begin
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] ad;
        int          sel;

        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        exp_rd = 32'h0;
        check("reset_busy", 32'(busywait), 32'h0);
        check("reset_rdata", read_data, 32'h0);
        check("reset_mis", 32'(misaligned), 32'h0);

        for (int w = 0; w < DEPTH; w++) access(4'b0, 3'b110, 32'(w * 4), $urandom);

        access(4'b0,    3'b110, 32'h10, 32'hDEADBEEF);
        access(4'b1010, 3'b000, 32'h10, 32'h0);
        check("lw_plan", read_data, 32'hDEADBEEF);
        access(4'b0,    3'b100, 32'h13, 32'h80);
        access(4'b1000, 3'b000, 32'h13, 32'h0);
        check("lb_plan", read_data, 32'hFFFFFF80);
        access(4'b1100, 3'b000, 32'h13, 32'h0);
        check("lbu_plan", read_data, 32'h00000080);
        access(4'b1010, 3'b000, 32'h10, 32'h0);
        check("lw_sb_plan", read_data, 32'h80ADBEEF);
        access(4'b0,    3'b101, 32'h12, 32'h8001);
        access(4'b1001, 3'b000, 32'h12, 32'h0);
        check("lh_plan", read_data, 32'hFFFF8001);
        access(4'b1101, 3'b000, 32'h12, 32'h0);
        check("lhu_plan", read_data, 32'h00008001);
        access(4'b1010, 3'b000, 32'h10, 32'h0);
        check("lw_sh_plan", read_data, 32'h8001BEEF);

        access(4'b1001, 3'b000, 32'h11, 32'h0);
        access(4'b0,    3'b110, 32'h0E, 32'h12345678);
        access(4'b1010, 3'b000, 32'h0C, 32'h0);

        reset_mid_store(32'h20, 32'hCAFEF00D);
        access(4'b1010, 3'b000, 32'h20, 32'h0);

        access(4'b0,    3'b110, 32'h400, 32'h11223344);
        access(4'b1010, 3'b000, 32'h000, 32'h0);
        check("alias_plan", read_data, 32'h11223344);

        access(4'b1010, 3'b110, 32'h30, 32'hA5A5A5A5);
        access(4'b1010, 3'b000, 32'h30, 32'h0);
        check("both_plan", read_data, 32'hA5A5A5A5);

        access(4'b0, 3'b0, 32'h44, 32'h0);

        for (int k = 0; k < 400; k++) begin
            sel = $urandom_range(0, 9);
            rd  = {1'b0, 3'($urandom)};
            wr  = {1'b0, 2'($urandom)};
            if (sel >= 1 && sel <= 4) rd[3] = 1'b1;
            if (sel >= 5) wr[2] = 1'b1;
            if (sel == 9) rd[3] = 1'b1;
            ad = $urandom;
            if ($urandom_range(0, 1) == 0) ad[1:0] = 2'b00;
            access(rd, wr, ad, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
